// File: rtl/udm_bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package udm_bus_arb_pkg;

    localparam int BUS_AW  = 32;
    localparam int BUS_DW  = 32;
    localparam int BUS_BEW = 4;

    // Returned to a master whose read was abandoned by the watchdog.
    localparam logic [BUS_DW-1:0] ERR_RDATA_DEFAULT = 32'hDEADC0DE;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

    // Request fields of one master, muxed as a unit toward the slave.
    typedef struct packed {
        logic              we;
        logic [BUS_AW-1:0] addr;
        logic [BUS_BEW-1:0] be;
        logic [BUS_DW-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/udm_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the master not granted last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the winner.
module udm_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    // Winner index: on a tie flip away from the previous grant, otherwise take whoever asks.
    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/udm_bus_arb.sv
// Shares one system bus between the UDM master (m0) and a second master (m1), holding the grant per transaction.
// Latency: request to s_req_o one cycle; ack/resp pass straight through; one IDLE cycle between transactions.
// Backpressure: masters hold req until ack; the loser stays pending; a watchdog ends reads the slave never answers.
module udm_bus_arb
    import udm_bus_arb_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [BUS_DW-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               m0_req_i,
    input  logic               m0_we_i,
    input  logic [BUS_AW-1:0]  m0_addr_bi,
    input  logic [BUS_BEW-1:0] m0_be_bi,
    input  logic [BUS_DW-1:0]  m0_wdata_bi,
    output logic               m0_ack_o,
    output logic               m0_resp_o,
    output logic [BUS_DW-1:0]  m0_rdata_bo,
    input  logic               m1_req_i,
    input  logic               m1_we_i,
    input  logic [BUS_AW-1:0]  m1_addr_bi,
    input  logic [BUS_BEW-1:0] m1_be_bi,
    input  logic [BUS_DW-1:0]  m1_wdata_bi,
    output logic               m1_ack_o,
    output logic               m1_resp_o,
    output logic [BUS_DW-1:0]  m1_rdata_bo,
    output logic               s_req_o,
    output logic               s_we_o,
    output logic [BUS_AW-1:0]  s_addr_bo,
    output logic [BUS_BEW-1:0] s_be_bo,
    output logic [BUS_DW-1:0]  s_wdata_bo,
    input  logic               s_ack_i,
    input  logic               s_resp_i,
    input  logic [BUS_DW-1:0]  s_rdata_bi,
    output logic               err_o
);

    // Counter only has to reach TIMEOUT_CYCLES-1; it saturates instead of wrapping.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              sel;
    logic              last_grant;
    logic [CNT_W-1:0]  wd_cnt;
    logic              pick_vld;
    logic              pick_winner;
    logic              ack_vld;
    logic              resp_vld;
    logic [BUS_DW-1:0] resp_dat;
    logic              timeout_hit;
    bus_req_t          m0_fields;
    bus_req_t          m1_fields;
    bus_req_t          sel_fields;

    udm_rr_pick2 u_pick (
        .req        ({m1_req_i, m0_req_i}),
        .last_grant (last_grant),
        .valid      (pick_vld),
        .winner     (pick_winner)
    );

    assign m0_fields   = {m0_we_i, m0_addr_bi, m0_be_bi, m0_wdata_bi};
    assign m1_fields   = {m1_we_i, m1_addr_bi, m1_be_bi, m1_wdata_bi};
    assign sel_fields  = sel ? m1_fields : m0_fields;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == CNT_LAST);

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant owner, round-robin history and read watchdog counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel        <= 1'b0;
            last_grant <= 1'b1;
            wd_cnt     <= '0;
        end else begin
            if (state == IDLE && pick_vld) begin
                sel <= pick_winner;
            end
            if (state == GRANT && s_ack_i) begin
                last_grant <= sel;
                wd_cnt     <= '0;
            end else if (state == WAIT_RESP && !resp_vld && wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    // Next state, slave-side mux and master strobes steered to the owner only.
    always_comb begin
        state_nxt  = state;
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_bo  = '0;
        s_be_bo    = '0;
        s_wdata_bo = '0;
        ack_vld    = 1'b0;
        resp_vld   = 1'b0;
        resp_dat   = '0;
        err_o      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                s_req_o    = 1'b1;
                s_we_o     = sel_fields.we;
                s_addr_bo  = sel_fields.addr;
                s_be_bo    = sel_fields.be;
                s_wdata_bo = sel_fields.wdata;
                if (s_ack_i) begin
                    ack_vld   = 1'b1;
                    state_nxt = sel_fields.we ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (s_resp_i) begin
                    resp_vld  = 1'b1;
                    resp_dat  = s_rdata_bi;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    resp_vld  = 1'b1;
                    resp_dat  = ERR_RDATA;
                    err_o     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        m0_ack_o    = ack_vld & ~sel;
        m1_ack_o    = ack_vld & sel;
        m0_resp_o   = resp_vld & ~sel;
        m1_resp_o   = resp_vld & sel;
        m0_rdata_bo = (resp_vld && !sel) ? resp_dat : '0;
        m1_rdata_bo = (resp_vld && sel) ? resp_dat : '0;
    end

endmodule

// File: doc/udm_bus_arb.md
# udm_bus_arb

Two-master bus arbiter that shares the single system bus (CSR and test-memory slaves) between the UDM debug master and a second master (CPU/DMA). It performs round-robin arbitration, holds the grant for the whole transaction, and includes a read-response watchdog. It sits between `udm` and the bus interconnect in the NEXYS4_DDR top.

## Interface

- `TIMEOUT_CYCLES`, default 1024: read-response watchdog limit in cycles after ack; 0 disables the watchdog.
- `ERR_RDATA`, default 32'hDEADC0DE: read data returned to the master when the watchdog expires.
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `mN_req_i` (N = 0 for UDM, 1 for the second master), in, 1: transaction request.
- `mN_we_i`, in, 1: 1 for write, 0 for read.
- `mN_addr_bi`, in, 32: byte address.
- `mN_be_bi`, in, 4: byte enables.
- `mN_wdata_bi`, in, 32: write data.
- `mN_ack_o`, out, 1: request accepted by the slave.
- `mN_resp_o`, out, 1: read data valid.
- `mN_rdata_bo`, out, 32: read data.
- `s_req_o`, `s_we_o`, `s_addr_bo`[32], `s_be_bo`[4], `s_wdata_bo`[32], out: the granted master's request toward the slave.
- `s_ack_i`, `s_resp_i`, in, 1: slave accept and read-response strobes.
- `s_rdata_bi`, in, 32: slave read data.
- `err_o`, out, 1: one-cycle pulse on watchdog expiry.

## Operation

- FSM states:
  - IDLE: no grant.
  - GRANT: `s_req_o` driven from the selected master.
  - WAIT_RESP: read outstanding.
- IDLE transitions:
  - If any `mN_req_i` is high, register the winner in `sel` and go to GRANT.
  - With only one master requesting, that master wins.
  - With both requesting, the master not equal to `last_grant` wins.
  - `last_grant` resets to 1, so m0 wins the first tie.
- GRANT:
  - `s_*` outputs come from a combinational mux of the live inputs of master `sel`.
  - Masters must hold req and all fields stable until ack. A master dropping req before ack is a protocol violation; its behaviour is undefined.
  - On `s_ack_i`: `m[sel]_ack_o`=1 in the same cycle, `last_grant`<=`sel`.
  - After the ack, a write goes to IDLE and a read goes to WAIT_RESP with the watchdog counter cleared.
- WAIT_RESP:
  - `s_req_o`=0.
  - On `s_resp_i`: `m[sel]_resp_o`=1 and `m[sel]_rdata_bo`=`s_rdata_bi` in the same cycle, then go to IDLE.
  - Otherwise, if `TIMEOUT_CYCLES`≠0 and the counter equals `TIMEOUT_CYCLES`-1: `m[sel]_resp_o`=1, `rdata`=`ERR_RDATA`, `err_o`=1, then go to IDLE.
  - Otherwise the counter increments. It is wide enough for `TIMEOUT_CYCLES` and never wraps.
- `s_ack_i` or `s_resp_i` arriving in IDLE, or `s_resp_i` arriving in GRANT, is ignored; no master strobe is generated. This covers late responses after a timeout.
- The non-granted master sees ack=resp=0. Its request stays pending and is served at the next IDLE.
- `mN_rdata_bo` is 0 whenever `mN_resp_o`=0.

## Timing

- Reset values: all `mN_ack_o`, `mN_resp_o`, `mN_rdata_bo`, `s_req_o`, `s_we_o`, `s_addr_bo`, `s_be_bo`, `s_wdata_bo` and `err_o` are 0; FSM=IDLE; `sel`=0; `last_grant`=1; counter=0.
- Reset taken in any state clears everything at that edge. Outputs are 0 in the following cycle and the in-flight transaction is abandoned without strobes.
- Request latency: `mN_req_i` first seen in IDLE at cycle t gives `s_req_o`=1 at t+1.
- Ack and resp are combinational pass-throughs: zero added latency.
- Back-to-back:
  - After a write ack at cycle t, the next grant drives `s_req_o` at t+2 (one IDLE cycle).
  - After a read resp at cycle t, the same applies: next grant at t+2.
- Two masters requesting continuously alternate m0, m1, m0, …
- Watchdog: with ack at cycle a and no response, the error resp appears at cycle a+`TIMEOUT_CYCLES`.

## Structure

- `udm_bus_arb_pkg`:
  - state enum (IDLE, GRANT, WAIT_RESP);
  - `BUS_AW`=32, `BUS_DW`=32, `BUS_BEW`=4;
  - default `ERR_RDATA`.
- One sub-module, `udm_rr_pick2`: combinational 2-way round-robin picker (inputs `req`[2] and `last_grant`; outputs `valid` and `winner`). The FSM, counter and muxes stay in `udm_bus_arb`.

## Test plan

- Write path: m0 writes 0x112233CC to 0x10000000 with be=0xF, slave acks 2 cycles after `s_req_o` → `s_addr_bo`/`s_wdata_bo` match; exactly one `m0_ack_o` pulse; `m1_ack_o` stays 0; FSM returns to IDLE.
- Arbitration: both masters request continuously after reset, the slave acks every write immediately → grant order m0, m1, m0, m1; each `s_req_o` rises 2 cycles after the previous ack.
- Read path: m1 reads 0x20000004, slave acks, then asserts `s_resp_i` 3 cycles later with 0xDEADBEEF → `m1_resp_o`=1 with `m1_rdata_bo`=0xDEADBEEF in that same cycle; nothing on m0.
- Watchdog: `TIMEOUT_CYCLES`=16, m0 reads 0x20000000 and the slave acks but never responds → 16 cycles after ack `m0_resp_o`=1 with `rdata`=0xDEADC0DE and `err_o` pulses once. A late `s_resp_i` 5 cycles later produces no strobe.
- Reset mid-read: assert `rst_i` for 1 cycle while in WAIT_RESP → all outputs 0 in the next cycle. A subsequent m1 request is granted with 1-cycle latency, and m0 wins the next tie.
